// File: rtl/life_controller.sv
// Generation sequencer for the Game of Life grid: it owns the lockstep gen_en pulse,
// provides run/edit/single-step modes, and drives the edit cursor and the paint strobe.
module life_controller #(
  parameter int unsigned N        = 8,
  parameter int unsigned CW       = 3,
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned GEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SW_pause,
  input  logic             SW_activate,
  input  logic [3:0]       KEY,
  output logic             gen_en,
  output logic             paint,
  output logic [N*N-1:0]   cell_sel,
  output logic [CW-1:0]    cursor_row,
  output logic [CW-1:0]    cursor_col,
  output logic [GEN_W-1:0] gen_count,
  output logic             running
);

  localparam int unsigned NC = N * N;
  localparam int unsigned IW = 2 * CW;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_EDIT = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Bit 1 = pause/run switch, bit 0 = activate switch
  logic [1:0]       sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [3:0]       key_meta_q, key_meta_d, key_sync_q, key_sync_d, key_prev_q, key_prev_d;
  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    row_q, row_d, col_q, col_d;
  logic [NC-1:0]    cell_sel_q, cell_sel_d;
  logic             gen_en_q, gen_en_d, paint_q, paint_d, running_q, running_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic [3:0]       key_press;
  logic             pause_s, act_s;

  always_comb begin
    sw_meta_d   = {SW_pause, SW_activate};
    sw_sync_d   = sw_meta_q;
    key_meta_d  = KEY;
    key_sync_d  = key_meta_q;
    key_prev_d  = key_sync_q;
    state_d     = state_q;
    presc_d     = presc_q;
    row_d       = row_q;
    col_d       = col_q;
    gen_en_d    = 1'b0;
    paint_d     = 1'b0;
    pause_s     = sw_sync_q[1];
    act_s       = sw_sync_q[0];
    key_press   = key_prev_q & ~key_sync_q;

    case (state_q)
      S_EDIT: begin
        presc_d = '0;
        // Entering RUN wins over any key press sampled in the same cycle
        if (pause_s) begin
          state_d = S_RUN;
        end else if (act_s) begin
          if (key_press[0]) begin
            paint_d = 1'b1;
          end else if (key_press[1]) begin
            state_d  = S_STEP;
            gen_en_d = 1'b1;
          end
        end else begin
          if (key_press[3] && !key_press[2]) col_d = col_q - CW'(1);
          else if (key_press[2] && !key_press[3]) col_d = col_q + CW'(1);
          if (key_press[1] && !key_press[0]) row_d = row_q - CW'(1);
          else if (key_press[0] && !key_press[1]) row_d = row_q + CW'(1);
        end
      end
      S_STEP: state_d = S_EDIT;
      S_RUN: begin
        if (!pause_s) begin
          state_d = S_EDIT;
          presc_d = '0;
        end else if (presc_q == TERM) begin
          presc_d  = '0;
          gen_en_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = S_EDIT;
    endcase

    running_d   = (state_d == S_RUN);
    gen_count_d = gen_en_d ? gen_count_q + GEN_W'(1) : gen_count_q;
    // Row-major one-hot select; N is a power of two so row*N+col is a concatenation
    for (int unsigned i = 0; i < NC; i++) begin
      cell_sel_d[i] = (IW'(i) == {row_d, col_d});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      key_meta_q  <= '1;
      key_sync_q  <= '1;
      key_prev_q  <= '1;
      state_q     <= S_EDIT;
      presc_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cell_sel_q  <= NC'(1);
      gen_en_q    <= 1'b0;
      paint_q     <= 1'b0;
      running_q   <= 1'b0;
      gen_count_q <= '0;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      key_prev_q  <= key_prev_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cell_sel_q  <= cell_sel_d;
      gen_en_q    <= gen_en_d;
      paint_q     <= paint_d;
      running_q   <= running_d;
      gen_count_q <= gen_count_d;
    end
  end

  assign gen_en     = gen_en_q;
  assign paint      = paint_q;
  assign cell_sel   = cell_sel_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign gen_count  = gen_count_q;
  assign running    = running_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller (TICK_DIV=4, GEN_W=2) with a pulse scoreboard
// holding the expected edge number and payload of every gen_en and paint pulse.
module tb_life_controller;

  logic        clk = 1'b0;
  logic        reset, SW_pause, SW_activate;
  logic [3:0]  KEY;
  logic        gen_en, paint, running;
  logic [63:0] cell_sel;
  logic [2:0]  cursor_row, cursor_col;
  logic [1:0]  gen_count;

  life_controller #(.N(8), .CW(3), .TICK_DIV(4), .GEN_W(2)) dut (
    .clk(clk), .reset(reset), .SW_pause(SW_pause), .SW_activate(SW_activate), .KEY(KEY),
    .gen_en(gen_en), .paint(paint), .cell_sel(cell_sel), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .gen_count(gen_count), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int at; logic [1:0] cnt; } gen_exp_t;
  typedef struct { int at; logic [2:0] row; logic [2:0] col; } paint_exp_t;
  gen_exp_t   gen_q[$];
  paint_exp_t paint_q[$];
  logic [1:0] exp_gen = 2'd0;
  logic [2:0] erow = 3'd0, ecol = 3'd0;

  function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function void push_gen(input int at);
    exp_gen = exp_gen + 2'd1;
    gen_q.push_back('{at: at, cnt: exp_gen});
  endfunction

  // Per-cycle monitor: pulses must land exactly on scoreboard cycles, nowhere else
  always @(negedge clk) begin
    if (!reset) begin
      check("cell_sel_consistent", cell_sel, 64'd1 << {cursor_row, cursor_col});
      check("gen_paint_exclusive", 64'(gen_en & paint), 64'd0);
      if (gen_q.size() > 0 && gen_q[0].at == cyc) begin
        check("gen_en_expected", 64'(gen_en), 64'd1);
        if (gen_en) check("gen_count_at_pulse", 64'(gen_count), 64'(gen_q[0].cnt));
        void'(gen_q.pop_front());
      end else begin
        check("gen_en_idle", 64'(gen_en), 64'd0);
      end
      if (paint_q.size() > 0 && paint_q[0].at == cyc) begin
        check("paint_expected", 64'(paint), 64'd1);
        if (paint) begin
          check("paint_row", 64'(cursor_row), 64'(paint_q[0].row));
          check("paint_col", 64'(cursor_col), 64'(paint_q[0].col));
          check("paint_not_running", 64'(running), 64'd0);
        end
        void'(paint_q.pop_front());
      end else begin
        check("paint_idle", 64'(paint), 64'd0);
      end
    end
  end

  task automatic check_cursor(input logic [2:0] r, input logic [2:0] c);
    check("cursor_row", 64'(cursor_row), 64'(r));
    check("cursor_col", 64'(cursor_col), 64'(c));
    check("cell_sel", cell_sel, 64'd1 << {r, c});
  endtask

  // kind: 0 = cursor move/ignored, 1 = paint, 2 = single step
  task automatic press(input logic [3:0] mask, input int hold, input int kind);
    @(negedge clk);
    KEY = ~mask;
    if (kind == 1) paint_q.push_back('{at: cyc + 3, row: erow, col: ecol});
    else if (kind == 2) push_gen(cyc + 3);
    repeat (hold) @(negedge clk);
    KEY = 4'hF;
    repeat (4) @(negedge clk);
  endtask

  // Hold SW_pause high for `hold` cycles; RUN starts 3 edges after the switch rises
  task automatic run(input int hold, input logic [3:0] entry_mask, input logic [3:0] mid_mask);
    int c;
    @(negedge clk);
    c = cyc;
    SW_pause = 1'b1;
    KEY = ~entry_mask;
    for (int e = c + 7; e <= c + hold + 2; e += 4) push_gen(e);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == 2) check("running_before_entry", 64'(running), 64'd0);
      if (i == 4) check("running_in_run", 64'(running), 64'd1);
      if (i == 6 && hold > 10) KEY = ~mid_mask;
      if (i == 9) KEY = 4'hF;
    end
    SW_pause = 1'b0;
    KEY = 4'hF;
    repeat (5) @(negedge clk);
    check("running_after_exit", 64'(running), 64'd0);
    check("gen_count_frozen", 64'(gen_count), 64'(exp_gen));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; SW_pause = 1'b0; SW_activate = 1'b0; KEY = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_gen_en", 64'(gen_en), 64'd0);
    check("rst_paint", 64'(paint), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_gen_count", 64'(gen_count), 64'd0);
    check_cursor(3'd0, 3'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Cursor moves with wrap, opposing-key cancel, and combined diagonal move
    press(4'b1000, 2, 0); check_cursor(3'd0, 3'd7);
    press(4'b0001, 2, 0);
    press(4'b0001, 2, 0); check_cursor(3'd2, 3'd7);
    check("cell_sel_bit23", 64'(cell_sel[23]), 64'd1);
    press(4'b1100, 2, 0); check_cursor(3'd2, 3'd7);
    press(4'b0101, 2, 0); check_cursor(3'd3, 3'd0);
    for (int i = 0; i < 4; i++) press(4'b0010, 2, 0);
    check_cursor(3'd7, 3'd0);
    erow = 3'd7; ecol = 3'd0;

    // Free run; key presses at RUN entry and mid-run must not move the cursor
    run(20, 4'b0100, 4'b1000);
    check_cursor(3'd7, 3'd0);
    // Pause exactly as a terminal count would land, then a fresh full-length run
    run(8, 4'b0000, 4'b0000);
    run(20, 4'b0000, 4'b0000);

    // Single step, paint beating step, ignored move keys in activate mode
    SW_activate = 1'b1;
    repeat (4) @(negedge clk);
    press(4'b0010, 2, 2);
    check("gen_count_after_step", 64'(gen_count), 64'(exp_gen));
    press(4'b0011, 2, 1);
    check("gen_count_after_paint", 64'(gen_count), 64'(exp_gen));
    press(4'b1000, 2, 0);
    check_cursor(3'd7, 3'd0);

    // Long hold yields one paint
    press(4'b0001, 50, 1);

    // Asynchronous reset in the middle of RUN with gen_count at 3
    @(negedge clk);
    c = cyc;
    SW_pause = 1'b1;
    push_gen(c + 7);
    repeat (9) @(negedge clk);
    check("pre_reset_gen_count", 64'(gen_count), 64'd3);
    check("pre_reset_running", 64'(running), 64'd1);
    check("pre_reset_queue_empty", 64'(gen_q.size()), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_gen_en", 64'(gen_en), 64'd0);
    check("async_rst_paint", 64'(paint), 64'd0);
    check("async_rst_running", 64'(running), 64'd0);
    check("async_rst_gen_count", 64'(gen_count), 64'd0);
    check_cursor(3'd0, 3'd0);
    SW_pause = 1'b0;
    exp_gen = 2'd0; erow = 3'd0; ecol = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Five generations wrap the 2-bit counter: 1,2,3,0,1; no paint while running
    run(22, 4'b0001, 4'b0001);
    check("gen_count_wrapped", 64'(gen_count), 64'd1);
    check_cursor(3'd0, 3'd0);
    SW_activate = 1'b0;
    repeat (4) @(negedge clk);
    press(4'b1100, 2, 0);
    check_cursor(3'd0, 3'd0);

    repeat (10) @(negedge clk);
    check("gen_queue_drained", 64'(gen_q.size()), 64'd0);
    check("paint_queue_drained", 64'(paint_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
